// File: rtl/line_drawer.sv
// All-octant Bresenham line walker feeding the VGA pixel-write port.
// One pixel per clock, responder side of the start/done handshake.
module line_drawer #(
   parameter int unsigned XW = 9,
   parameter int unsigned YW = 8,
   parameter int unsigned CW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [XW-1:0] x0,
   input  logic [XW-1:0] x1,
   input  logic [YW-1:0] y0,
   input  logic [YW-1:0] y1,
   input  logic [CW-1:0] colour,
   output logic          plot,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [CW-1:0] col_out,
   output logic          done
);

   localparam int unsigned MW = (XW > YW) ? XW : YW;
   localparam int unsigned DW = MW + 1;
   localparam int unsigned EW = MW + 2;

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRAW, S_DONE} state_t;

   state_t               state_q;
   logic [XW-1:0]        x_q, x1_q;
   logic [YW-1:0]        y_q, y1_q;
   logic [CW-1:0]        col_q;
   logic signed [DW-1:0] dx_q, dy_q;
   logic                 sx_neg_q, sy_neg_q;
   logic signed [EW-1:0] err_q;

   logic signed [DW-1:0] x0_s, x1_s, y0_s, y1_s, dx_c, dy_c;
   logic signed [EW-1:0] e2_c, dx_e, dy_e, err_d;
   logic [XW-1:0]        x_d;
   logic [YW-1:0]        y_d;
   logic                 at_end_c;

   // Setup math (INIT) uses x_q/y_q, which already hold the latched start point.
   always_comb begin
      x0_s = $signed({{(DW-XW){1'b0}}, x_q});
      x1_s = $signed({{(DW-XW){1'b0}}, x1_q});
      y0_s = $signed({{(DW-YW){1'b0}}, y_q});
      y1_s = $signed({{(DW-YW){1'b0}}, y1_q});
      dx_c = (x1_s > x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
      dy_c = (y1_s > y0_s) ? (y0_s - y1_s) : (y1_s - y0_s);
   end

   // One Bresenham step; both axis updates may fire together.
   always_comb begin
      dx_e     = EW'(dx_q);
      dy_e     = EW'(dy_q);
      e2_c     = err_q <<< 1;
      err_d    = err_q;
      x_d      = x_q;
      y_d      = y_q;
      at_end_c = (x_q == x1_q) && (y_q == y1_q);
      if (e2_c >= dy_e) begin
         err_d = err_d + dy_e;
         x_d   = sx_neg_q ? (x_q - XW'(1)) : (x_q + XW'(1));
      end
      if (e2_c <= dx_e) begin
         err_d = err_d + dx_e;
         y_d   = sy_neg_q ? (y_q - YW'(1)) : (y_q + YW'(1));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         x1_q     <= '0;
         y1_q     <= '0;
         col_q    <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
         err_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  x_q     <= x0;
                  y_q     <= y0;
                  x1_q    <= x1;
                  y1_q    <= y1;
                  col_q   <= colour;
                  state_q <= S_INIT;
               end
            end
            S_INIT: begin
               dx_q     <= dx_c;
               dy_q     <= dy_c;
               sx_neg_q <= !(x_q < x1_q);
               sy_neg_q <= !(y_q < y1_q);
               err_q    <= EW'(dx_c) + EW'(dy_c);
               state_q  <= S_DRAW;
            end
            S_DRAW: begin
               if (at_end_c) begin
                  state_q <= S_DONE;
               end else begin
                  x_q   <= x_d;
                  y_q   <= y_d;
                  err_q <= err_d;
               end
            end
            S_DONE: begin
               if (!start) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign plot    = (state_q == S_DRAW);
   assign done    = (state_q == S_DONE);
   assign x       = x_q;
   assign y       = y_q;
   assign col_out = col_q;

endmodule

// File: tb/tb_line_drawer.sv
// Randomized self-checking bench for line_drawer against a plain integer
// Bresenham reference that enumerates the expected pixel list.
module tb_line_drawer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [8:0] x0 = '0, x1 = '0;
   logic [7:0] y0 = '0, y1 = '0;
   logic [2:0] colour = '0;
   logic       plot, done;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] col_out;

   int checks = 0;
   int errors = 0;

   int exp_x[$], exp_y[$];
   int cap_x[$], cap_y[$], cap_c[$];
   int first_cyc, last_cyc, done_cyc, nplot;
   bit both_high;

   line_drawer dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1), .colour(colour),
      .plot(plot), .x(x), .y(y), .col_out(col_out), .done(done)
   );

   always #5 clk = ~clk;

   // Expected pixel list for a line, built with plain integers.
   task automatic model(input int xa, input int ya, input int xb, input int yb);
      int dx, dy, sx, sy, err, e2, cx, cy;
      exp_x.delete();
      exp_y.delete();
      dx  = (xb > xa) ? xb - xa : xa - xb;
      dy  = -((yb > ya) ? yb - ya : ya - yb);
      sx  = (xa < xb) ? 1 : -1;
      sy  = (ya < yb) ? 1 : -1;
      err = dx + dy;
      cx  = xa;
      cy  = ya;
      for (int n = 0; n < 1000; n++) begin
         exp_x.push_back(cx);
         exp_y.push_back(cy);
         if (cx == xb && cy == yb) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; cx += sx; end
         if (e2 <= dx) begin err += dx; cy += sy; end
      end
   endtask

   // Index of first captured pixel differing from the model, -2 on length mismatch, -1 if equal.
   function automatic int first_diff(input int c);
      if (cap_x.size() != exp_x.size()) return -2;
      for (int i = 0; i < cap_x.size(); i++)
         if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != c) return i;
      return -1;
   endfunction

   // Issue a line request (call just after a negedge) and capture plots until done.
   task automatic draw(input int xa, input int ya, input int xb, input int yb, input int c,
                       input bit drop_on_plot, input bit change_mid, input bit hold);
      cap_x.delete(); cap_y.delete(); cap_c.delete();
      first_cyc = -1; last_cyc = -1; done_cyc = -1; nplot = 0; both_high = 0;
      x0 = 9'(xa); y0 = 8'(ya); x1 = 9'(xb); y1 = 8'(yb); colour = 3'(c);
      start = 1'b1;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(negedge clk);
         if (plot && done) both_high = 1;
         if (plot) begin
            cap_x.push_back(int'(x));
            cap_y.push_back(int'(y));
            cap_c.push_back(int'(col_out));
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            nplot++;
            if (drop_on_plot) start = 1'b0;
            if (change_mid) begin
               x0 = 9'($urandom_range(0, 319));
               x1 = 9'($urandom_range(0, 319));
               y0 = 8'($urandom_range(0, 239));
               y1 = 8'($urandom_range(0, 239));
               colour = ~colour;
            end
         end
         if (done) begin
            done_cyc = cyc;
            if (!hold) start = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      start   = 1'b1;
      x0 = 9'd33; y0 = 8'd44; x1 = 9'd55; y1 = 8'd66; colour = 3'd5;
      repeat (3) @(negedge clk);
      checks++; if (plot !== 1'b0)    begin errors++; $display("FAIL reset_plot got %b want 0", plot); end
      checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (x !== 9'd0)       begin errors++; $display("FAIL reset_x got %0d want 0", x); end
      checks++; if (y !== 8'd0)       begin errors++; $display("FAIL reset_y got %0d want 0", y); end
      checks++; if (col_out !== 3'd0) begin errors++; $display("FAIL reset_col got %0d want 0", col_out); end
      start   = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_horizontal;
      int d;
      model(0, 0, 4, 0);
      draw(0, 0, 4, 0, 4, 0, 0, 0);
      d = first_diff(4);
      checks++; if (d !== -1) begin errors++; $display("FAIL horiz_pixels first bad index %0d want -1", d); end
      checks++; if (nplot !== 5) begin errors++; $display("FAIL horiz_count got %0d want 5", nplot); end
      checks++; if (first_cyc !== 2) begin errors++; $display("FAIL horiz_latency got %0d want 2", first_cyc); end
      checks++; if (done_cyc !== last_cyc + 1 || last_cyc - first_cyc + 1 != nplot)
         begin errors++; $display("FAIL horiz_timing done %0d last %0d first %0d", done_cyc, last_cyc, first_cyc); end
      checks++; if (both_high !== 1'b0) begin errors++; $display("FAIL horiz_plot_done_overlap got 1 want 0"); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL horiz_done_release got %b want 0", done); end
   endtask

   task automatic test_steep;
      int d;
      model(10, 10, 8, 4);
      draw(10, 10, 8, 4, 2, 0, 0, 0);
      d = first_diff(2);
      checks++; if (d !== -1) begin errors++; $display("FAIL steep_pixels first bad index %0d want -1", d); end
      checks++; if (nplot !== 7) begin errors++; $display("FAIL steep_count got %0d want 7", nplot); end
      checks++; if (cap_x.size() == 7 && (cap_x[2] != 9 || cap_y[2] != 8))
         begin errors++; $display("FAIL steep_pixel2 got (%0d,%0d) want (9,8)", cap_x[2], cap_y[2]); end
      @(negedge clk);
   endtask

   task automatic test_single_point;
      int d;
      model(5, 7, 5, 7);
      draw(5, 7, 5, 7, 6, 1, 0, 0);
      d = first_diff(6);
      checks++; if (d !== -1) begin errors++; $display("FAIL single_pixel first bad index %0d want -1", d); end
      checks++; if (nplot !== 1) begin errors++; $display("FAIL single_count got %0d want 1", nplot); end
      checks++; if (done_cyc !== first_cyc + 1) begin errors++; $display("FAIL single_done_cyc got %0d want %0d", done_cyc, first_cyc + 1); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done); end
   endtask

   task automatic test_full_screen;
      int d, bad_adv;
      model(0, 0, 319, 239);
      draw(0, 0, 319, 239, 7, 0, 0, 0);
      d = first_diff(7);
      checks++; if (d !== -1) begin errors++; $display("FAIL full_pixels first bad index %0d want -1", d); end
      checks++; if (nplot !== 320) begin errors++; $display("FAIL full_count got %0d want 320", nplot); end
      checks++; if (nplot == 320 && (cap_x[319] != 319 || cap_y[319] != 239))
         begin errors++; $display("FAIL full_last got (%0d,%0d) want (319,239)", cap_x[319], cap_y[319]); end
      bad_adv = 0;
      foreach (cap_x[i]) if (cap_x[i] != i) bad_adv++;
      checks++; if (bad_adv !== 0) begin errors++; $display("FAIL full_x_advance got %0d bad cycles want 0", bad_adv); end
      @(negedge clk);
   endtask

   task automatic test_hold_start;
      int bad, d;
      int xa, ya, xb, yb, c;
      draw(3, 3, 6, 1, 1, 0, 0, 1);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (done !== 1'b1 || plot !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL hold_done got %0d bad cycles want 0", bad); end
      start = 1'b0;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", done); end
      xa = $urandom_range(0, 319); ya = $urandom_range(0, 239);
      xb = $urandom_range(0, 319); yb = $urandom_range(0, 239);
      c  = $urandom_range(0, 7);
      model(xa, ya, xb, yb);
      draw(xa, ya, xb, yb, c, 0, 0, 0);
      d = first_diff(c);
      checks++; if (d !== -1) begin errors++; $display("FAIL second_line (%0d,%0d)->(%0d,%0d) bad index %0d", xa, ya, xb, yb, d); end
      @(negedge clk);
   endtask

   task automatic test_input_change;
      int d;
      model(20, 30, 40, 10);
      draw(20, 30, 40, 10, 3, 0, 1, 0);
      d = first_diff(3);
      checks++; if (d !== -1) begin errors++; $display("FAIL midchange_pixels first bad index %0d want -1", d); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_draw;
      int seen, d;
      x0 = 9'd2; y0 = 8'd5; x1 = 9'd12; y1 = 8'd9; colour = 3'd5;
      start = 1'b1;
      seen = 0;
      for (int cyc = 0; cyc < 50 && seen < 3; cyc++) begin
         @(negedge clk);
         if (plot) seen++;
      end
      reset_n = 1'b0;
      #1;
      checks++; if ({plot, done, x, y, col_out} !== '0)
         begin errors++; $display("FAIL midreset_outputs got plot %b done %b x %0d y %0d col %0d want all 0", plot, done, x, y, col_out); end
      @(negedge clk);
      reset_n = 1'b1;
      model(2, 5, 12, 9);
      draw(2, 5, 12, 9, 5, 0, 0, 0);
      d = first_diff(5);
      checks++; if (d !== -1) begin errors++; $display("FAIL midreset_restart first bad index %0d want -1", d); end
      checks++; if (first_cyc !== 2) begin errors++; $display("FAIL midreset_latency got %0d want 2", first_cyc); end
      @(negedge clk);
   endtask

   task automatic test_random;
      int xa, ya, xb, yb, c, d, want_n, adx, ady;
      for (int t = 0; t < 25; t++) begin
         xa = $urandom_range(0, 319); ya = $urandom_range(0, 239);
         xb = $urandom_range(0, 319); yb = $urandom_range(0, 239);
         c  = $urandom_range(0, 7);
         adx = (xb > xa) ? xb - xa : xa - xb;
         ady = (yb > ya) ? yb - ya : ya - yb;
         want_n = ((adx > ady) ? adx : ady) + 1;
         model(xa, ya, xb, yb);
         draw(xa, ya, xb, yb, c, 0, 0, 0);
         d = first_diff(c);
         checks++; if (d !== -1 || nplot != want_n || done_cyc != last_cyc + 1 || both_high)
            begin errors++; $display("FAIL random_line (%0d,%0d)->(%0d,%0d) bad index %0d plots %0d want %0d done %0d last %0d",
                                     xa, ya, xb, yb, d, nplot, want_n, done_cyc, last_cyc); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_horizontal();
      test_steep();
      test_single_point();
      test_full_screen();
      test_hold_start();
      test_input_change();
      test_reset_mid_draw();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
